// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder, one time-shared full adder, LSB first.
// Define SERIAL_ADD_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, ps, ps_nxt;
    logic [CW-1:0] cnt;
    logic c, hs1, hc1, s, hc2, co, last;
    always_comb begin
        hs1 = a_sr[0] ^ b_sr[0];
        hc1 = a_sr[0] & b_sr[0];
        s = hs1 ^ c;
        hc2 = hs1 & c;
        co = hc1 | hc2;
        // sum bit enters at the MSB so after WIDTH shifts bit 0 lands at the LSB
        ps_nxt = (ps >> 1) | (WIDTH'(s) << (WIDTH - 1));
        last = cnt == CW'(WIDTH - 1);
        state_nxt = state == IDLE ? (start ? RUN : IDLE) :
                    state == RUN  ? (last ? DONE : RUN) : IDLE;
    end
    assign busy = state != IDLE;
    assign done = state == DONE;
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            ps <= '0;
            cnt <= '0;
            c <= 1'b0;
            sum <= '0;
            cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf <= 1'b0;
`endif
        end else if (state == IDLE && start) begin
            a_sr <= a;
            b_sr <= b;
            c <= cin;
            cnt <= '0;
        end else if (state == RUN) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            c <= co;
            ps <= ps_nxt;
            cnt <= cnt + CW'(1);
            if (last) begin
                sum <= ps_nxt;
                cout <= co;
`ifdef SERIAL_ADD_OVF_EN
                ovf <= c ^ co;
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for WIDTH=4 and WIDTH=1 instances.
// Checks ovf as well when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic start4 = 1'b0, start1 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic cin4 = 1'b0, busy4, done4, cout4;
    logic a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, busy1, done1, sum1, cout1;
`ifdef SERIAL_ADD_OVF_EN
    logic ovf4, ovf1;
`endif
    int cyc = 0, errors = 0, checks = 0;
    logic [3:0] last4 = '0;
    logic last1 = 1'b0;
    typedef struct {
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
        int         due;
    } exp_t;
    exp_t q4[$], q1[$];
    // {a, b, cin, sum, cout, ovf}
    logic [14:0] v4 [8] = '{
        {4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b1},
        {4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0},
        {4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0},
        {4'h3, 4'h4, 1'b1, 4'h8, 1'b0, 1'b1},
        {4'h7, 4'h7, 1'b1, 4'hF, 1'b0, 1'b1},
        {4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1},
        {4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0},
        {4'hA, 4'h6, 1'b0, 4'h0, 1'b1, 1'b0}
    };
    // indexed by {a, b, cin}: {sum, cout, ovf}
    logic [2:0] v1 [8] = '{3'b000, 3'b101, 3'b100, 3'b010, 3'b100, 3'b010, 3'b011, 3'b110};

    serial_add_ctrl #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf4)
`endif
    );
    serial_add_ctrl #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf1)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic push4(int i);
        exp_t e;
        e.sum = v4[i][5:2];
        e.cout = v4[i][1];
        e.ovf = v4[i][0];
        e.due = cyc + 4;
        q4.push_back(e);
    endtask

    task automatic go4(int i);
        {a4, b4, cin4} = v4[i][14:6];
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        push4(i);
        {a4, b4, cin4} = ~v4[i][14:6];
        repeat (5) tick();
    endtask

    always @(negedge clk) begin
        if (rst) last4 = '0;
        else if (done4) begin
            if (q4.size() == 0) chk("unexpected_done4", 1, 0);
            else begin
                exp_t e;
                e = q4.pop_front();
                chk("sum4", sum4, e.sum);
                chk("cout4", cout4, e.cout);
`ifdef SERIAL_ADD_OVF_EN
                chk("ovf4", ovf4, e.ovf);
`endif
                chk("latency4", cyc, e.due);
                last4 = e.sum;
            end
        end else if (busy4) chk("hold4", sum4, last4);
    end

    always @(negedge clk) begin
        if (rst) last1 = 1'b0;
        else if (done1) begin
            if (q1.size() == 0) chk("unexpected_done1", 1, 0);
            else begin
                exp_t e;
                e = q1.pop_front();
                chk("sum1", sum1, e.sum[0]);
                chk("cout1", cout1, e.cout);
`ifdef SERIAL_ADD_OVF_EN
                chk("ovf1", ovf1, e.ovf);
`endif
                chk("latency1", cyc, e.due);
                last1 = e.sum[0];
            end
        end else if (busy1) chk("hold1", sum1, last1);
    end

    initial begin
        {a4, b4, cin4} = v4[0][14:6];
        start4 = 1'b1;
        repeat (3) tick();
        chk("rst_busy4", busy4, 0);
        chk("rst_done4", done4, 0);
        chk("rst_sum4", sum4, 0);
        chk("rst_cout4", cout4, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_sum1", sum1, 0);
        rst = 1'b0;
        start4 = 1'b0;
        go4(0);
        go4(1);
        go4(2);
        // start held high: only every sixth edge may accept, in-flight operands disturbed
        start4 = 1'b1;
        for (int i = 4; i < 8; i++) begin
            {a4, b4, cin4} = v4[i][14:6];
            tick();
            push4(i);
            repeat (5) begin
                a4 = 4'($urandom);
                b4 = 4'($urandom);
                cin4 = 1'($urandom);
                tick();
            end
        end
        start4 = 1'b0;
        repeat (2) tick();
        {a4, b4, cin4} = v4[2][14:6];
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy4", busy4, 0);
        chk("midrst_done4", done4, 0);
        chk("midrst_sum4", sum4, 0);
        chk("midrst_cout4", cout4, 0);
        repeat (6) tick();
        go4(3);
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            {a1, b1, cin1} = 3'(i);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            e.sum = {3'b000, v1[i][2]};
            e.cout = v1[i][1];
            e.ovf = v1[i][0];
            e.due = cyc + 1;
            q1.push_back(e);
            {a1, b1, cin1} = ~3'(i);
            repeat (2) tick();
        end
        for (int i = 0; i < 50 && (q4.size() != 0 || q1.size() != 0); i++) tick();
        chk("drain", q4.size() + q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin one addition; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A, captured on accepted start.
REQ-006 Port: b  input  WIDTH  operand B, captured on accepted start.
REQ-007 Port: cin  input  1  carry-in, captured on accepted start.
REQ-008 Port: busy  output  1  high while in RUN or DONE.
REQ-009 Port: done  output  1  single-cycle pulse marking a valid result.
REQ-010 Port: sum  output  WIDTH  registered result of the last completed addition.
REQ-011 Port: cout  output  1  registered carry-out of the last completed addition.
REQ-012 Port: ovf  output  1  signed-overflow flag; present only when SERIAL_ADD_OVF_EN is defined.

Function
REQ-013 Adder: a single 1-bit full adder, built from two half adders and an OR, is time-shared over all bit positions, LSB first.
REQ-014 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-015 IDLE: on start=1, load a and b into operand shift registers and cin into the carry flop, clear the bit counter, and go to RUN; on start=0, stay in IDLE.
REQ-016 RUN, each cycle: add the operand LSBs plus the carry flop; shift the sum bit into the MSB of the partial-sum register; store the full-adder carry; shift both operands right by one; increment the counter.
REQ-017 RUN exit: when counter==WIDTH-1, complete that bit, copy the partial sum to sum and the final carry to cout, and go to DONE.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-019 Latency: with start sampled at edge k, RUN spans edges k+1..k+WIDTH and done is high in the cycle after edge k+WIDTH; one addition takes WIDTH+2 cycles from start to the next acceptable start.
REQ-020 start is ignored while busy=1, including in DONE; captured operands are not disturbed.
REQ-021 Input changes on a, b or cin after acceptance do not affect the in-flight result.
REQ-022 sum and cout hold their values from the previous completion until the next DONE entry, and do not change during RUN.
REQ-023 Result satisfies {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1).
REQ-024 WIDTH=1: RUN lasts exactly one cycle and is followed by DONE.

Reset
REQ-025 rst=1 at a clock edge forces IDLE and clears the counter, shift registers and carry flop, and sets busy=0, done=0, sum=0, cout=0 and ovf=0.
REQ-026 rst overrides start and any state; an addition interrupted mid-RUN is discarded with no done pulse.
REQ-027 First start is accepted at the first edge where rst=0 and start=1.

Configuration
REQ-028 Macro SERIAL_ADD_OVF_EN defined: port ovf exists and is loaded at DONE entry with (carry into MSB) XOR (carry out of MSB), i.e. two's-complement overflow; it holds like sum.
REQ-029 SERIAL_ADD_OVF_EN undefined: no ovf port and no overflow logic; all other behaviour is identical.

Verification
REQ-030 WIDTH=4, a=0101, b=0011, cin=0, start pulse at edge k -> done high only after edge k+4; sum=1000, cout=0, ovf=1.
REQ-031 a=1111, b=0001, cin=0 -> sum=0000, cout=1, ovf=0; then a=1111, b=1111, cin=1 -> sum=1111, cout=1, ovf=0.
REQ-032 Hold start=1 continuously with changing operands -> additions accepted every 6 cycles only; each result matches the operands captured at acceptance.
REQ-033 Assert rst at the 2nd RUN cycle -> next cycle busy=0, sum=0, cout=0, no done pulse; a fresh start then yields a correct result.
REQ-034 WIDTH=1, a=1, b=1, cin=1 -> done after edge k+1, sum=1, cout=1; exhaustive 8-case sweep matches a+b+cin.
